// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci sequencer: FSM encoding,
// default sizing and the saturation helpers used for results and statistics.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDXW  = 6;
  localparam int MAX_WIDTH = 64;
  localparam int STAT_W    = 16;

  // Largest positive value of a w-bit result: MSB clear, all lower bits set.
  function automatic logic [MAX_WIDTH-1:0] sat_value(input int unsigned w);
    logic [MAX_WIDTH-1:0] all_but_msb;
    all_but_msb = {1'b0, {(MAX_WIDTH-1){1'b1}}};
    return all_but_msb >> (MAX_WIDTH - w);
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc_sat(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fib_step_core.sv
// Shared Fibonacci step datapath: holds the (previous, current) pair,
// restarts it on clear and advances it one term per step.
module fib_step_core
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [WIDTH-1:0] previous,
  output logic             current_msb
);

  logic [WIDTH-1:0] previous_reg;
  logic [WIDTH-1:0] current_reg;

  // Additions wrap modulo 2^WIDTH; the sequencer stops stepping before a wrap matters.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      previous_reg <= '0;
      current_reg  <= WIDTH'(1);
    end else if (step) begin
      previous_reg <= current_reg;
      current_reg  <= current_reg + previous_reg;
    end
  end

  assign previous    = previous_reg;
  assign current_msb = current_reg[WIDTH-1];

endmodule

// File: rtl/fib_sequencer.sv
// Round-robin front end for the shared Fibonacci datapath: arbitrates NREQ
// requesters, runs one job at a time and returns F(n). FIB_STATS_EN adds counters.
module fib_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDXW  = DEF_IDXW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*IDXW-1:0]     req_index,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_value,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic                     resp_overflow
`ifdef FIB_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_done,
  output logic [STAT_W-1:0]        stat_ovf
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [WIDTH-1:0] SAT_RESULT = WIDTH'(sat_value(WIDTH));

  state_t           state_reg;
  logic [IDW-1:0]   ptr_reg;
  logic [IDXW-1:0]  count_reg;

  logic [IDXW-1:0]  idx_slot   [NREQ];
  logic [IDW-1:0]   cand_idx   [NREQ];
  logic [NREQ-1:0]  cand_valid;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_onehot;
  logic [IDW-1:0]   ptr_next;
  logic             accept;

  logic             dp_clear;
  logic             dp_step;
  logic [WIDTH-1:0] dp_previous;
  logic             dp_current_msb;

  // Candidate gi is the requester gi positions after the pointer, wrapping at NREQ.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slot
      logic [IDW:0] rot_sum;
      assign idx_slot[gi]   = req_index[gi*IDXW +: IDXW];
      assign rot_sum        = {1'b0, ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi]   = (rot_sum >= (IDW+1)'(NREQ)) ?
                              IDW'(rot_sum - (IDW+1)'(NREQ)) : rot_sum[IDW-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  always_comb begin
    grant_onehot = '0;
    if (state_reg == IDLE && !reset && grant_found) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_onehot;
  assign accept    = |grant_onehot;
  assign ptr_next  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  assign dp_clear   = accept;
  assign dp_step    = (state_reg == RUN) && (count_reg != '0) && !dp_current_msb;
  assign resp_valid = (state_reg == DONE);

  fib_step_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .reset       (reset),
    .clear       (dp_clear),
    .step        (dp_step),
    .previous    (dp_previous),
    .current_msb (dp_current_msb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      count_reg     <= '0;
      resp_value    <= '0;
      resp_id       <= '0;
      resp_overflow <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg <= idx_slot[grant_idx];
            resp_id   <= grant_idx;
            ptr_reg   <= ptr_next;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (count_reg == '0) begin
            resp_value    <= dp_previous;
            resp_overflow <= 1'b0;
            state_reg     <= DONE;
          end else if (dp_current_msb) begin
            // A term with the MSB set is already too big, so F(n) can only be larger.
            resp_value    <= SAT_RESULT;
            resp_overflow <= 1'b1;
            state_reg     <= DONE;
          end else begin
            count_reg <= count_reg - IDXW'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef FIB_STATS_EN
  logic [STAT_W-1:0] stat_done_reg;
  logic [STAT_W-1:0] stat_ovf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_done_reg <= '0;
      stat_ovf_reg  <= '0;
    end else if (resp_valid && resp_ready) begin
      stat_done_reg <= stat_inc_sat(stat_done_reg);
      if (resp_overflow) begin
        stat_ovf_reg <= stat_inc_sat(stat_ovf_reg);
      end
    end
  end

  assign stat_done = stat_done_reg;
  assign stat_ovf  = stat_ovf_reg;
`endif

endmodule
